// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared RV32I EX/MEM types: branch funct3 codes, writeback
//            select encodings and the EX/MEM pipeline register layout.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int EM_XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  typedef struct packed {
    logic [EM_XLEN-1:0] alu_result;
    logic [EM_XLEN-1:0] write_data;
    logic [EM_XLEN-1:0] pc_plus4;
    logic [4:0]         rd;
    logic               reg_write;
    logic               mem_write;
    logic               mem_read;
    logic [1:0]         result_src;
  } ex_mem_t;

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
// Module   : branch_cond
// Purpose  : Conditional-branch evaluation from ALU flags of A-B
//            (C=1 means no borrow).
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  input  logic       c,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = z;
      F3_BNE:  cond = !z;
      F3_BLT:  cond = n ^ v;
      F3_BGE:  cond = !(n ^ v);
      F3_BLTU: cond = !c;
      F3_BGEU: cond = c;
      default: cond = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX/MEM pipeline register with branch resolution, one-cycle PC
//            redirect and wrong-path squash. Define EX_SKID_EN for a one-entry
//            skid buffer with a registered in_ready. XLEN must equal EM_XLEN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int XLEN          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            z,
  input  logic            n,
  input  logic            v,
  input  logic            c,
  input  logic [XLEN-1:0] write_data,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] pc_target,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_write,
  input  logic            mem_read,
  input  logic [1:0]      result_src,
  input  logic            branch,
  input  logic            jump,
  input  logic [2:0]      funct3,
  input  logic            ext_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] m_alu_result,
  output logic [XLEN-1:0] m_write_data,
  output logic [XLEN-1:0] m_pc_plus4,
  output logic [4:0]      m_rd,
  output logic            m_reg_write,
  output logic            m_mem_write,
  output logic            m_mem_read,
  output logic [1:0]      m_result_src,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  ex_mem_t         main_q, main_d, in_pkt;
  logic            out_valid_q, out_valid_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [2:0]      squash_cnt_q, squash_cnt_d;
  logic            cond, taken, xfer_in, squashing, accept, main_free;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .z      (z),
    .n      (n),
    .v      (v),
    .c      (c),
    .cond   (cond)
  );

  assign in_pkt    = '{alu_result, write_data, pc_plus4, rd,
                       reg_write, mem_write, mem_read, result_src};
  assign taken     = jump | (branch & cond);
  assign main_free = !out_valid_q || out_ready;
  assign xfer_in   = in_valid && in_ready;
  assign squashing = (squash_cnt_q != 3'd0);
  assign accept    = xfer_in && !squashing;

`ifdef EX_SKID_EN
  ex_mem_t skid_q, skid_d;
  logic    skid_valid_q, skid_valid_d;

  // Skid occupancy is a flop, so out_ready never reaches in_ready.
  assign in_ready = !rst && !skid_valid_q;
`else
  assign in_ready = !rst && main_free;
`endif

  always_comb begin
    main_d        = main_q;
    out_valid_d   = out_valid_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    squash_cnt_d  = squash_cnt_q;
`ifdef EX_SKID_EN
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;
`endif

    if (squashing && xfer_in) begin
      squash_cnt_d = squash_cnt_q - 3'd1;
    end else if (accept && taken) begin
      squash_cnt_d  = 3'(SQUASH_CYCLES);
      redirect_d    = 1'b1;
      redirect_pc_d = pc_target;
    end

`ifdef EX_SKID_EN
    if (skid_valid_q) begin
      if (main_free) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_free) begin
        main_d      = in_pkt;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_pkt;
        skid_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`else
    if (accept) begin
      main_d      = in_pkt;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`endif

    // Flush drops the incoming instruction and any pending redirect/squash;
    // register contents are left alone, only the valids fall.
    if (ext_flush) begin
      main_d        = main_q;
      out_valid_d   = 1'b0;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      squash_cnt_d  = 3'd0;
`ifdef EX_SKID_EN
      skid_d        = skid_q;
      skid_valid_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q        <= '0;
      out_valid_q   <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      squash_cnt_q  <= 3'd0;
`ifdef EX_SKID_EN
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
`endif
    end else begin
      main_q        <= main_d;
      out_valid_q   <= out_valid_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      squash_cnt_q  <= squash_cnt_d;
`ifdef EX_SKID_EN
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign m_alu_result = main_q.alu_result;
  assign m_write_data = main_q.write_data;
  assign m_pc_plus4   = main_q.pc_plus4;
  assign m_rd         = main_q.rd;
  assign m_reg_write  = main_q.reg_write;
  assign m_mem_write  = main_q.mem_write;
  assign m_mem_read   = main_q.mem_read;
  assign m_result_src = main_q.result_src;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Scoreboard bench for ex_mem_stage (directed vectors).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, z, n, v, c;
  logic [31:0] alu_result, write_data, pc_plus4, pc_target;
  logic [4:0]  rd;
  logic        reg_write, mem_write, mem_read, branch, jump, ext_flush;
  logic [1:0]  result_src;
  logic [2:0]  funct3;
  logic        out_valid, out_ready, m_reg_write, m_mem_write, m_mem_read;
  logic [31:0] m_alu_result, m_write_data, m_pc_plus4, redirect_pc;
  logic [4:0]  m_rd;
  logic [1:0]  m_result_src;
  logic        redirect;

  ex_mem_stage #(.SQUASH_CYCLES(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .z(z), .n(n), .v(v), .c(c),
    .write_data(write_data), .pc_plus4(pc_plus4), .pc_target(pc_target),
    .rd(rd), .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
    .result_src(result_src), .branch(branch), .jump(jump), .funct3(funct3),
    .ext_flush(ext_flush), .out_valid(out_valid), .out_ready(out_ready),
    .m_alu_result(m_alu_result), .m_write_data(m_write_data),
    .m_pc_plus4(m_pc_plus4), .m_rd(m_rd), .m_reg_write(m_reg_write),
    .m_mem_write(m_mem_write), .m_mem_read(m_mem_read),
    .m_result_src(m_result_src), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    ex_mem_t     f;
    logic [31:0] tgt;
    logic        br, jmp;
    logic [2:0]  f3;
    logic [3:0]  zncv;
    logic        flush, kept, redir;
  } vec_t;

  ex_mem_t     sb[$];
  logic [31:0] rq[$];
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] tgt,
                              input logic br, input logic jmp, input logic [2:0] f3,
                              input logic [3:0] zncv, input logic kept, input logic redir);
    vec_t t;
    t.f.alu_result = alu;
    t.f.write_data = ~alu;
    t.f.pc_plus4   = alu + 32'd4;
    t.f.rd         = alu[4:0];
    t.f.reg_write  = alu[0];
    t.f.mem_write  = alu[1];
    t.f.mem_read   = alu[2];
    t.f.result_src = alu[4:3];
    t.tgt = tgt; t.br = br; t.jmp = jmp; t.f3 = f3; t.zncv = zncv;
    t.flush = 1'b0; t.kept = kept; t.redir = redir;
    return t;
  endfunction

  function automatic ex_mem_t dut_m();
    return '{m_alu_result, m_write_data, m_pc_plus4, m_rd,
             m_reg_write, m_mem_write, m_mem_read, m_result_src};
  endfunction

  task automatic send(input vec_t t);
    bit ok = 1'b0;
    {alu_result, write_data, pc_plus4} = {t.f.alu_result, t.f.write_data, t.f.pc_plus4};
    {rd, reg_write, mem_write, mem_read, result_src} =
      {t.f.rd, t.f.reg_write, t.f.mem_write, t.f.mem_read, t.f.result_src};
    pc_target = t.tgt; branch = t.br; jump = t.jmp; funct3 = t.f3;
    {z, n, v, c} = t.zncv; ext_flush = t.flush; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 128'(t.f.alu_result), 128'hDEAD);
    else begin
      if (t.kept)  sb.push_back(t.f);
      if (t.redir) rq.push_back(t.tgt);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; ext_flush = 1'b0; branch = 1'b0; jump = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT hands off or redirects.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 128'(m_alu_result), 128'hE0E0);
        else chk("out_fields", 128'(dut_m()), 128'(sb.pop_front()));
      end
      if (redirect) begin
        if (rq.size() == 0) chk("unexpected_redirect", 128'(redirect_pc), 128'hE1E1);
        else chk("redirect_pc", 128'(redirect_pc), 128'(rq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_mem_t held;
    vec_t    t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ext_flush = 1'b0;
    {alu_result, write_data, pc_plus4, pc_target} = '0;
    {rd, reg_write, mem_write, mem_read, result_src} = '0;
    {branch, jump, funct3, z, n, v, c} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",    128'(in_ready),     128'd0);
    chk("rst_out_valid",   128'(out_valid),    128'd0);
    chk("rst_redirect",    128'(redirect),     128'd0);
    chk("rst_redirect_pc", 128'(redirect_pc),  128'd0);
    chk("rst_m_fields",    128'(dut_m()),      128'd0);
    @(posedge clk); #1; rst = 1'b0;

    // BEQ taken, two squashed followers, third kept
    send(mk(32'h0,  32'h100, 1, 0, F3_BEQ, 4'b1000, 1, 1));
    send(mk(32'h11, 32'h0,   0, 0, 3'b000, 4'b0000, 0, 0));
    send(mk(32'h22, 32'h0,   0, 0, 3'b000, 4'b0000, 0, 0));
    send(mk(32'h33, 32'h0,   0, 0, 3'b000, 4'b0000, 1, 0));
    // BLTU with c=1 not taken, then back-to-back follower
    send(mk(32'h44, 32'h900, 1, 0, F3_BLTU, 4'b0001, 1, 0));
    send(mk(32'h55, 32'h0,   0, 0, 3'b000,  4'b0000, 1, 0));
    @(negedge clk);
    chk("latency_valid", 128'(out_valid),    128'd1);
    chk("latency_alu",   128'(m_alu_result), 128'h55);
    @(posedge clk); #1;
    // BLT: n=v not taken; n!=v taken
    send(mk(32'h66, 32'h900, 1, 0, F3_BLT, 4'b0110, 1, 0));
    send(mk(32'h77, 32'h200, 1, 0, F3_BLT, 4'b0100, 1, 1));
    idle(3);
    // Jump during squash is squashed; idle cycles did not consume the count
    send(mk(32'h88, 32'h300, 0, 1, 3'b000, 4'b0000, 0, 0));
    send(mk(32'h99, 32'h0,   0, 0, 3'b000, 4'b0000, 0, 0));
    send(mk(32'hAA, 32'h0,   0, 0, 3'b000, 4'b0000, 1, 0));
    // Not-taken corners: BGEU c=0, BGE n!=v, funct3=010 with z=1, BNE z=1
    send(mk(32'hA1, 32'h900, 1, 0, F3_BGEU, 4'b0000, 1, 0));
    send(mk(32'hA2, 32'h900, 1, 0, F3_BGE,  4'b0100, 1, 0));
    send(mk(32'hA3, 32'h900, 1, 0, 3'b010,  4'b1000, 1, 0));
    send(mk(32'hA4, 32'h900, 1, 0, F3_BNE,  4'b1000, 1, 0));
    idle(1);

    // Stall: outputs held for 5 cycles
    out_ready = 1'b0;
    send(mk(32'hBB, 32'h0, 0, 0, 3'b000, 4'b0000, 1, 0));
    held = mk(32'hBB, 32'h0, 0, 0, 3'b000, 4'b0000, 1, 0).f;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", 128'(dut_m()), 128'(held));
`ifndef EX_SKID_EN
      chk("stall_in_ready", 128'(in_ready), 128'd0);
`endif
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(mk(32'hCC, 32'h0, 0, 0, 3'b000, 4'b0000, 1, 0));
    @(negedge clk);
    chk("release_no_bubble", 128'({out_valid, m_alu_result}), 128'({1'b1, 32'hCC}));
    @(posedge clk); #1;

    // Taken jump with simultaneous flush: dropped, no redirect
    t = mk(32'hDD, 32'h500, 0, 1, 3'b000, 4'b0000, 0, 0);
    t.flush = 1'b1;
    send(t);
    @(negedge clk);
    chk("flush_redirect",  128'(redirect),  128'd0);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk); #1;
    send(mk(32'hEE, 32'h0, 0, 0, 3'b000, 4'b0000, 1, 0));
    idle(1);

`ifdef EX_SKID_EN
    out_ready = 1'b0;
    send(mk(32'h1A1, 32'h0, 0, 0, 3'b000, 4'b0000, 1, 0));
    send(mk(32'h1B1, 32'h0, 0, 0, 3'b000, 4'b0000, 1, 0));
    @(negedge clk);
    chk("skid_full_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("skid_b_next", 128'({out_valid, m_alu_result}), 128'({1'b1, 32'h1B1}));
    idle(1);
`endif

    // Reset during a stall loses the pending instruction
    out_ready = 1'b0;
    send(mk(32'hF0, 32'h0, 0, 0, 3'b000, 4'b0000, 1, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("midstall_rst_valid", 128'(out_valid),    128'd0);
    chk("midstall_rst_alu",   128'(m_alu_result), 128'd0);
    rst = 1'b0; out_ready = 1'b1;
    send(mk(32'h123, 32'h0, 0, 0, 3'b000, 4'b0000, 1, 0));
    idle(3);

    chk("sb_drained",       128'(sb.size()), 128'd0);
    chk("redirect_drained", 128'(rq.size()), 128'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the RV32I core. It registers the ALU result, flags and control fields into the EX/MEM boundary. It resolves conditional branches and jumps from the ALU Z/N/V/C flags, issues a one-cycle PC redirect, and squashes the wrong-path instructions that follow a taken redirect. It sits directly downstream of the ALU and feeds the data-memory stage through a valid/ready handshake.

## Interface
Parameters:
- SQUASH_CYCLES, 2: number of wrong-path upstream transfers discarded after a taken redirect (1..7).
- XLEN, 32: datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid EX instruction.
- in_ready  out  1  stage accepts this cycle.
- alu_result  in  XLEN  ALU Result.
- z, n, v, c  in  1 each  ALU zero/negative/overflow/carry flags.
- write_data  in  XLEN  store data (rs2 after forwarding).
- pc_plus4, pc_target  in  XLEN  link address and branch/jump target.
- rd  in  5  destination register.
- reg_write, mem_write, mem_read  in  1 each  control.
- result_src  in  2  writeback select.
- branch, jump  in  1 each  conditional branch / unconditional jump.
- funct3  in  3  branch condition code.
- ext_flush  in  1  trap/exception flush.
- out_valid  out  1  EX/MEM register holds a valid instruction.
- out_ready  in  1  memory stage accepts.
- m_alu_result, m_write_data, m_pc_plus4  out  XLEN  registered copies.
- m_rd  out  5; m_reg_write, m_mem_write, m_mem_read  out  1; m_result_src  out  2.
- redirect  out  1  taken branch/jump; one-cycle pulse.
- redirect_pc  out  XLEN  new fetch PC, valid when redirect=1.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Branch taken conditions. The ALU performed A−B, so C=1 means no borrow.
  - 000 BEQ: z.
  - 001 BNE: !z.
  - 100 BLT: n^v.
  - 101 BGE: !(n^v).
  - 110 BLTU: !c.
  - 111 BGEU: c.
  - 010/011: never taken.
- taken = jump | (branch & cond).
- On an accepted, non-squashed instruction:
  - All m_* fields load from the inputs and out_valid is set.
  - If taken: redirect=1 and redirect_pc=pc_target on the next cycle. squash_cnt loads SQUASH_CYCLES.
- Squash:
  - While squash_cnt≠0, every upstream transfer is consumed (in_ready follows the normal rule) but not written.
  - squash_cnt decrements by 1 per consumed transfer, not per cycle.
  - Cycles with in_valid=0 do not decrement.
- Stall: while out_valid && !out_ready, all m_* outputs are held bit-stable.
- ext_flush has priority over everything:
  - It clears out_valid, redirect and squash_cnt in the same edge.
  - Input presented that cycle is dropped.
  - redirect is suppressed even if a taken branch was accepted that cycle.
- Data outputs are not cleared on flush; only out_valid is cleared.
- Reset values: out_valid=0, redirect=0, redirect_pc=0, all m_* =0, squash_cnt=0. in_ready=0 while rst=1.

## Timing
- Latency: one cycle, from input transfer to out_valid and m_* valid.
- redirect rises the cycle after acceptance, lasts exactly one cycle, and is independent of out_ready.
- in_ready without skid = !out_valid | out_ready. This path is combinational from out_ready.
- Simultaneous out-transfer and in-transfer: the register reloads with no bubble.
- A taken branch accepted while squash_cnt≠0 is itself squashed: no redirect, counter continues.
- Reset mid-stall: the next edge with rst=1 clears all state. The pending instruction is lost.

## Configuration
- EX_SKID_EN defined:
  - Adds a one-entry skid register.
  - in_ready is registered and equals "skid empty"; no combinational out_ready→in_ready path.
  - Up to two instructions are buffered; ordering is preserved.
  - The squash/redirect decision is made at input transfer, before skid.
  - ext_flush empties both entries.
- Undefined: single register, in_ready as above.

## Structure
- riscv_pkg holds:
  - Branch funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - RESULT_SRC encodings.
  - The ex_mem_t packed struct (all m_* fields) used for the main and skid registers.
- Sub-module branch_cond: combinational (funct3, z, n, v, c) → cond. It is reused by any future early-branch logic.

## Test plan
- BEQ, alu_result=0, z=1, pc_target=0x100, out_ready=1 → out_valid next cycle; redirect=1, redirect_pc=0x100 for exactly one cycle; next two in_valid transfers not in m_*.
- BLTU with c=1 (A≥B) → no redirect; following instruction appears in m_* with one-cycle latency, back-to-back.
- BLT, n=1, v=1 → not taken; n=1, v=0 → taken.
- out_ready=0 for 5 cycles with out_valid=1 → m_* unchanged each cycle; without skid in_ready=0; on release, next input loads with no bubble.
- Taken jump accepted in the same cycle as ext_flush=1 → redirect stays 0, out_valid=0, squash_cnt=0; next instruction accepted normally.
- With EX_SKID_EN: out_ready=0, two inputs A, B → in_ready falls after A's acceptance+1; release → A then B on consecutive cycles.
